// File: rtl/sar_pkg.sv
// Shared types and sizing helpers for SAR conversion consumers.
package sar_pkg;

  localparam int CODE_W_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } sar_avg_state_t;

  // Accumulator / raw-sum width: holds N*(2^CODE_W-1) without overflow.
  function automatic int sum_w(input int code_w, input int log2_n);
    return code_w + log2_n;
  endfunction

endpackage

// File: rtl/sar_edge_det.sv
// Rising-edge detector for a level signal. History resets to 1 so a level
// already high when reset releases does not count as an edge.
module sar_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic lvl_i,
  output logic rise_o
);

  logic lvl_q;

  // Track the previous level every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) lvl_q <= 1'b1;
    else        lvl_q <= lvl_i;
  end

  assign rise_o = lvl_i & ~lvl_q;

endmodule

// File: rtl/sar_oversample_avg.sv
// Accumulates 2^LOG2_N SAR codes and presents a rounded average plus the
// raw sum through a valid/ready output register with sticky overrun.
module sar_oversample_avg
  import sar_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int LOG2_N = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [CODE_W-1:0]        code_in,
  input  logic                     conv_done,
  output logic [CODE_W-1:0]        out_avg,
  output logic [CODE_W+LOG2_N-1:0] out_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun,
  input  logic                     ovr_clr
);

  localparam int SUM_W = sum_w(CODE_W, LOG2_N);
  localparam int N     = 1 << LOG2_N;

  sar_avg_state_t    state_q, state_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CODE_W-1:0] avg_q, avg_d;
  logic              vld_q, vld_d;
  logic              ovr_q, ovr_d;

  logic              edge_w;
  logic              sample, blk_done, consume, load;
  logic [SUM_W-1:0]  total;
  logic [SUM_W:0]    rnd;

  sar_edge_det u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .lvl_i  (conv_done),
    .rise_o (edge_w)
  );

  assign sample   = edge_w & en & (state_q == ACCUM);
  assign blk_done = sample & (cnt_q == LOG2_N'(N - 1));
  assign total    = acc_q + {{LOG2_N{1'b0}}, code_in};
  // One extra bit so the half-LSB rounding add cannot wrap.
  assign rnd      = {1'b0, total} + (SUM_W + 1)'(N / 2);
  assign consume  = vld_q & out_ready;
  // A completed block only lands if the output slot is free or draining now.
  assign load     = blk_done & (~vld_q | out_ready);

  // Next-state for the FSM, accumulator and output register.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    avg_d   = avg_q;
    vld_d   = vld_q;
    ovr_d   = ovr_q;

    case (state_q)
      IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (en) state_d = ACCUM;
      end
      ACCUM: begin
        if (!en) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (blk_done) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (sample) begin
          acc_d = total;
          cnt_d = cnt_q + LOG2_N'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      sum_d = total;
      avg_d = CODE_W'(rnd >> LOG2_N);
      vld_d = 1'b1;
    end else if (consume) begin
      vld_d = 1'b0;
    end

    // Set wins over clear.
    if (blk_done & vld_q & ~out_ready) ovr_d = 1'b1;
    else if (ovr_clr)                  ovr_d = 1'b0;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      avg_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      avg_q   <= avg_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_avg   = avg_q;
  assign out_sum   = sum_q;
  assign out_valid = vld_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_sar_oversample_avg.sv
// Scoreboard bench: the stimulus driver predicts completed blocks from the
// sampling rules and queues expected results; a monitor pops on handshake.
module tb_sar_oversample_avg;

  localparam int CODE_W = 4;
  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     en;
  logic [CODE_W-1:0]        code_in;
  logic                     conv_done;
  logic [CODE_W-1:0]        out_avg;
  logic [CODE_W+LOG2_N-1:0] out_sum;
  logic                     out_valid;
  logic                     out_ready;
  logic                     overrun;
  logic                     ovr_clr;

  sar_oversample_avg #(.CODE_W(CODE_W), .LOG2_N(LOG2_N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .code_in   (code_in),
    .conv_done (conv_done),
    .out_avg   (out_avg),
    .out_sum   (out_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int exp_sum_q[$];
  int exp_avg_q[$];
  int blk[$];
  bit prev_en, prev_cd, m_valid, m_ovr;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; predicts what the following clock edge does.
  task automatic drive(input bit e, input bit cd, input int c, input bit r, input bit clr);
    bit edge_s, sample, consume, loaded, ovr_set;
    int total;
    @(posedge clk); #2;
    check("out_valid", int'(out_valid), int'(m_valid));
    check("overrun", int'(overrun), int'(m_ovr));
    en = e; conv_done = cd; code_in = CODE_W'(c); out_ready = r; ovr_clr = clr;
    // A sample needs a rising conv_done with en high now and at the previous edge.
    edge_s  = cd && !prev_cd;
    sample  = edge_s && e && prev_en;
    consume = m_valid && r;
    loaded  = 0;
    ovr_set = 0;
    if (!e) blk.delete();
    if (sample) begin
      blk.push_back(c & ((1 << CODE_W) - 1));
      if (blk.size() == N) begin
        total = 0;
        foreach (blk[i]) total += blk[i];
        blk.delete();
        if (!m_valid || consume) begin
          exp_sum_q.push_back(total);
          exp_avg_q.push_back((2 * total + N) / (2 * N));  // round half up
          loaded = 1;
        end else ovr_set = 1;
      end
    end
    if (loaded)       m_valid = 1;
    else if (consume) m_valid = 0;
    if (ovr_set)      m_ovr = 1;
    else if (clr)     m_ovr = 0;
    prev_en = e;
    prev_cd = cd;
  endtask

  task automatic samp(input int c, input bit r);
    drive(1, 1, c, r, 0);
    drive(1, 0, $urandom_range(0, 15), r, 0);
  endtask

  task automatic block(input int a, input int b, input int c, input int d, input bit r);
    samp(a, r); samp(b, r); samp(c, r); samp(d, r);
  endtask

  // Monitor: every handshake consumes one expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_sum_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        check("out_sum", int'(out_sum), exp_sum_q.pop_front());
        check("out_avg", int'(out_avg), exp_avg_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 0; en = 1; conv_done = 1; code_in = '0; out_ready = 0; ovr_clr = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_avg", int'(out_avg), 0);
    rst_n = 1;
    // en was high at the release edge, so the FSM enters ACCUM there.
    prev_en = 1; prev_cd = 1; m_valid = 0; m_ovr = 0;

    // conv_done held high through release: nothing is sampled.
    repeat (20) drive(1, 1, $urandom_range(0, 15), 0, 0);
    drive(1, 0, 0, 0, 0);

    // Basic block, held then consumed.
    block(3, 4, 4, 4, 0);
    repeat (3) drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);

    // Boundary codes, consumer always ready.
    block(15, 15, 15, 15, 1);
    block(15, 15, 15, 14, 1);
    block(0, 0, 0, 1, 1);
    repeat (2) drive(1, 0, 0, 1, 0);

    // Overrun: second block dropped while first is unconsumed.
    block(1, 1, 1, 1, 0);
    block(9, 9, 9, 9, 0);
    drive(1, 0, 0, 0, 1);
    repeat (2) drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);

    // Consume and load on the same edge.
    block(2, 3, 5, 7, 0);
    samp(8, 0); samp(8, 0); samp(8, 0);
    drive(1, 1, 6, 1, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);

    // Abort partial block; edge in the cycle en rises is ignored.
    samp(12, 1); samp(13, 1);
    drive(0, 0, 0, 1, 0);
    drive(1, 1, 7, 1, 0);
    drive(1, 0, 0, 1, 0);
    block(5, 6, 7, 8, 1);
    drive(1, 0, 0, 1, 0);

    // Randomized traffic.
    repeat (400)
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 1), $urandom_range(0, 15),
            $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);

    // Drain without new edges.
    repeat (4) drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    check("scoreboard_empty", exp_sum_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_oversample_avg.md
Name: sar_oversample_avg

Overview:
- Downstream consumer of the SAR conversion logic.
- Captures each completed conversion code on the rising edge of conv_done and accumulates 2^LOG2_N consecutive codes.
- Emits a rounded average code plus the raw sum through a valid/ready output register.
- Provides oversampling and noise reduction before the results reach the output pins or a serializer.

Parameters:
- CODE_W, 4, width of the SAR code input and of the averaged output.
- LOG2_N, 2, log2 of samples per average; legal range 1..6 (N = 2^LOG2_N).

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  accumulation enable; low aborts and clears the partial block.
- code_in  input  CODE_W  SAR result; valid in the cycle conv_done rises.
- conv_done  input  1  SAR conversion-complete level; only its rising edge counts.
- out_avg  output  CODE_W  rounded average of the last completed block.
- out_sum  output  CODE_W+LOG2_N  exact sum of the last completed block.
- out_valid  output  1  output register holds an unconsumed result.
- out_ready  input  1  consumer accepts the result when out_valid and out_ready are both high.
- overrun  output  1  sticky: a completed block was dropped.
- ovr_clr  input  1  clears overrun.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - acc=0, cnt=0, state=IDLE.
  - out_avg=0, out_sum=0, out_valid=0, overrun=0.
  - done_q=1, so a conv_done already high at reset release is not counted.
- Edge qualification:
  - edge = conv_done & ~done_q; done_q <= conv_done every cycle regardless of en.
  - A sample is taken when edge & en & state==ACCUM.
- FSM states:
  - IDLE: acc and cnt held at 0. If en=1, go to ACCUM next cycle. Edges seen in IDLE are ignored, including an edge in the same cycle en rises.
  - ACCUM, en=0: go to IDLE; acc and cnt clear at that edge; a pending sample in that cycle is discarded.
  - ACCUM, sample and cnt<N-1: acc += code_in, cnt += 1.
  - ACCUM, sample and cnt==N-1 (block complete): total = acc + code_in; acc and cnt clear at the same edge. Stay in ACCUM; next block starts immediately.
- Output load on block complete:
  - Condition: out_valid==0, or (out_valid & out_ready) in the same cycle.
  - out_sum <= total; out_avg <= (total + 2^(LOG2_N-1)) >> LOG2_N.
  - out_valid <= 1.
  - Latency: result visible one clk after the edge that samples the Nth code.
- Rounding width: the rounding add uses CODE_W+LOG2_N+1 bits. The result never exceeds 2^CODE_W-1, so no saturation logic is needed.
- Output consume: out_valid & out_ready with no simultaneous load clears out_valid. out_avg and out_sum hold their last values.
- Overrun:
  - Block complete while out_valid=1 and out_ready=0: the new result is discarded, the output register is unchanged, and overrun <= 1.
  - ovr_clr=1 clears overrun. If ovr_clr and a new overrun occur in the same cycle, overrun is set (set wins).
- Accumulator sizing: acc is CODE_W+LOG2_N bits and cannot overflow, since max sum = N*(2^CODE_W-1).
- en deassertion never touches out_* or overrun. Reset mid-block discards the partial sum.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package sar_pkg:
  - CODE_W default constant.
  - State enum type sar_avg_state_t {IDLE, ACCUM}.
  - Localparam helper for the sum width (CODE_W+LOG2_N).
- One natural sub-module: sar_edge_det (rising-edge detector, reset state 1). It is reusable for other conv_done consumers.

Test Plan:
- Reset release with conv_done held high, en=1, no further toggles -> no sample taken, out_valid stays 0 for 20 cycles.
- LOG2_N=2, codes 3,4,4,4, each on a conv_done rising edge -> out_sum=15, out_avg=4, out_valid=1 one clk after the 4th edge. out_ready=1 for one cycle -> out_valid=0.
- Codes 15,15,15,15 -> out_sum=60, out_avg=15 (no wrap). Codes 15,15,15,14 -> out_sum=59, out_avg=15. Codes 0,0,0,1 -> out_sum=1, out_avg=0.
- out_ready=0 while two blocks complete (blocks 1,1,1,1 then 9,9,9,9) -> output holds sum 4 / avg 1 and overrun=1. Pulse ovr_clr -> overrun=0. Output unchanged until out_ready.
- Block-complete edge in the same cycle as out_valid & out_ready -> new result loaded, out_valid stays 1 continuously, overrun stays 0.
- Two samples taken, en=0 for one cycle, en=1, then 4 more samples -> result reflects only the last 4 codes (partial sum discarded). Edge in the cycle en rises is ignored.
